// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, framing constants and the
// baud divisor helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  // Rounded clocks-per-oversample-tick.
  function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud);
    return (clk + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Valid/ready byte stream from the UART receiver to the CPU register logic.
interface uart_byte_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes; head is read directly from the
// register array so it changes only on a clock edge.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push is about to use.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 receive front end: rxd synchroniser, 16x oversampling FSM with
// mid-bit sampling, and a receive FIFO presented as a valid/ready stream.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           cpu_clk,
  input  logic           cpu_rst,
  input  logic           rxd,
  uart_byte_rx_if.master rx,
  output logic           frame_err,
  output logic           overrun,
  output logic           rx_busy
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [OW-1:0] OS_MID    = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic [1:0]           sync;
  logic                 rxd_s;
  logic [TW-1:0]        div_cnt;
  logic                 tick;
  rx_state_t            state;
  logic [OW-1:0]        os_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_sample;
  logic                 pop;
  logic                 push;
  logic                 room;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;

  assign rxd_s = sync[1];

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rxd};
    end
  end

  assign tick = (div_cnt == TICK_LAST);

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign pop         = rx.rx_valid && rx.rx_ready;
  assign room        = !fifo_full || pop;
  assign stop_sample = (state == STOP) && tick && (os_cnt == OS_LAST);
  assign push        = stop_sample && rxd_s && room;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            os_cnt <= '0;
            state  <= START;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt == OS_MID) begin
              if (rxd_s) begin
                state <= IDLE;
              end else begin
                os_cnt  <= '0;
                bit_idx <= '0;
                state   <= DATA;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        // os_cnt wraps from OS_LAST to zero, which re-arms the next bit period.
        DATA: begin
          if (tick) begin
            os_cnt <= os_cnt + 1'b1;
            if (os_cnt == OS_LAST) begin
              shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == BIT_LAST) begin
                state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            os_cnt <= os_cnt + 1'b1;
            if (os_cnt == OS_LAST) begin
              if (!rxd_s) begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end else begin
                overrun <= !room;
                state   <= IDLE;
              end
            end
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (cpu_clk),
    .rst       (cpu_rst),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx.rx_valid = !fifo_empty;
  assign rx.rx_data  = fifo_head;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 50 MHz / 115200 baud (27 clocks per tick,
// 432 per receiver bit); the line side is driven at 434 clocks per bit nominal.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  localparam int BIT_NOM  = 434;
  localparam int BIT_FAST = 421;
  localparam int BIT_SLOW = 447;
  localparam int TICK_CLK = 27;

  logic cpu_clk = 1'b0;
  logic cpu_rst;
  logic rxd;
  logic frame_err;
  logic overrun;
  logic rx_busy;

  uart_byte_rx_if rx_if ();

  uart_byte_rx #(
    .CLK_FREQ   (50_000_000),
    .BAUD       (115200),
    .FIFO_DEPTH (4)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .rxd       (rxd),
    .rx        (rx_if),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #10 cpu_clk = ~cpu_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fe_cyc = 0;
  int ov_cyc = 0;
  int ov_last = 0;
  int v_cyc = 0;
  logic [7:0] v_data = 8'h00;
  int last_start = 0;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  always @(negedge cpu_clk) begin
    if (frame_err === 1'b1) fe_cyc++;
    if (overrun === 1'b1) begin
      ov_cyc++;
      ov_last = cyc;
    end
    if (rx_if.rx_valid === 1'b1) begin
      v_cyc++;
      v_data = rx_if.rx_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge cpu_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_clks);
    last_start = cyc;
    rxd = 1'b0;
    repeat (bit_clks) @(negedge cpu_clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (bit_clks) @(negedge cpu_clk);
    end
    rxd = stop;
    repeat (bit_clks) @(negedge cpu_clk);
  endtask

  task automatic drain(input string tag, input logic [7:0] exp);
    int budget = 16;
    while (rx_if.rx_valid !== 1'b1 && budget > 0) begin
      @(negedge cpu_clk);
      budget--;
    end
    check_eq({tag, "_valid"}, 32'(rx_if.rx_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(rx_if.rx_data), 32'(exp));
    rx_if.rx_ready = 1'b1;
    @(negedge cpu_clk);
    rx_if.rx_ready = 1'b0;
  endtask

  initial begin
    #(95_000 * 20);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fe0, ov0, v0, t5, o5, m, t_start, t_ready;
    rxd = 1'b1;
    rx_if.rx_ready = 1'b0;
    cpu_rst = 1'b1;
    repeat (3) @(negedge cpu_clk);
    check_eq("rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check_eq("rst_data", 32'(rx_if.rx_data), 32'h00);
    check_eq("rst_busy", 32'(rx_busy), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    cpu_rst = 1'b0;
    idle(100);

    // single byte, consumer always ready
    fe0 = fe_cyc; ov0 = ov_cyc; v0 = v_cyc;
    rx_if.rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, BIT_NOM);
    idle(BIT_NOM);
    check_eq("a5_valid_cycles", 32'(v_cyc - v0), 32'd1);
    check_eq("a5_data", 32'(v_data), 32'hA5);
    check_eq("a5_ferr", 32'(fe_cyc - fe0), 32'd0);
    check_eq("a5_ovr", 32'(ov_cyc - ov0), 32'd0);
    check_eq("a5_valid_after", 32'(rx_if.rx_valid), 32'd0);

    // five bytes into a four-entry FIFO
    rx_if.rx_ready = 1'b0;
    fe0 = fe_cyc; ov0 = ov_cyc;
    t5 = 0;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, BIT_NOM);
      if (k == 5) t5 = last_start;
      idle(BIT_NOM);
    end
    o5 = ov_last;
    check_eq("ovr_pulses", 32'(ov_cyc - ov0), 32'd1);
    check_eq("ovr_ferr", 32'(fe_cyc - fe0), 32'd0);
    check_eq("full_valid", 32'(rx_if.rx_valid), 32'd1);
    check_eq("full_head", 32'(rx_if.rx_data), 32'h01);

    // byte 3C arrives on a full FIFO with a pop on its stop-sample clock;
    // same tick phase as byte 5, so the stop sample lands 27*m later
    m = 0;
    while (t5 + TICK_CLK * m < cyc + BIT_NOM) m++;
    t_start = t5 + TICK_CLK * m;
    t_ready = o5 + TICK_CLK * m - 1;
    ov0 = ov_cyc;
    while (cyc < t_start) @(negedge cpu_clk);
    fork
      send_frame(8'h3C, 1'b1, BIT_NOM);
      begin
        while (cyc < t_ready) @(negedge cpu_clk);
        check_eq("pop_at_stop_head", 32'(rx_if.rx_data), 32'h01);
        rx_if.rx_ready = 1'b1;
        @(negedge cpu_clk);
        rx_if.rx_ready = 1'b0;
      end
    join
    idle(BIT_NOM);
    check_eq("pop_at_stop_ovr", 32'(ov_cyc - ov0), 32'd0);
    drain("drain02", 8'h02);
    drain("drain03", 8'h03);
    drain("drain04", 8'h04);
    drain("drain3c", 8'h3C);
    idle(4);
    check_eq("drain_empty", 32'(rx_if.rx_valid), 32'd0);

    // stop bit low followed by a break
    fe0 = fe_cyc; ov0 = ov_cyc;
    send_frame(8'h5A, 1'b0, BIT_NOM);
    repeat (2 * BIT_NOM) @(negedge cpu_clk);
    check_eq("brk_ferr", 32'(fe_cyc - fe0), 32'd1);
    check_eq("brk_busy_low", 32'(rx_busy), 32'd1);
    check_eq("brk_no_push", 32'(rx_if.rx_valid), 32'd0);
    rxd = 1'b1;
    @(negedge cpu_clk);
    check_eq("brk_busy_edge", 32'(rx_busy), 32'd1);
    repeat (3) @(negedge cpu_clk);
    check_eq("brk_busy_high", 32'(rx_busy), 32'd0);
    idle(2 * BIT_NOM);
    check_eq("brk_no_restart", 32'(rx_busy), 32'd0);
    check_eq("brk_ferr_once", 32'(fe_cyc - fe0), 32'd1);
    check_eq("brk_ovr", 32'(ov_cyc - ov0), 32'd0);

    // 4-tick glitch on an idle line
    fe0 = fe_cyc; ov0 = ov_cyc;
    rxd = 1'b0;
    repeat (4 * TICK_CLK) @(negedge cpu_clk);
    check_eq("glitch_busy", 32'(rx_busy), 32'd1);
    idle(BIT_NOM);
    check_eq("glitch_idle", 32'(rx_busy), 32'd0);
    check_eq("glitch_valid", 32'(rx_if.rx_valid), 32'd0);
    check_eq("glitch_pulses", 32'(fe_cyc - fe0 + ov_cyc - ov0), 32'd0);

    // baud skew +/-3%
    fe0 = fe_cyc; ov0 = ov_cyc;
    send_frame(8'h00, 1'b1, BIT_FAST); idle(BIT_NOM);
    send_frame(8'hFF, 1'b1, BIT_SLOW); idle(BIT_NOM);
    send_frame(8'h55, 1'b1, BIT_FAST); idle(BIT_NOM);
    send_frame(8'h55, 1'b1, BIT_SLOW); idle(BIT_NOM);
    check_eq("skew_pulses", 32'(fe_cyc - fe0 + ov_cyc - ov0), 32'd0);
    drain("skew00", 8'h00);
    drain("skewff", 8'hFF);
    drain("skew55f", 8'h55);
    drain("skew55s", 8'h55);

    // reset mid-DATA with a byte still buffered
    send_frame(8'h96, 1'b1, BIT_NOM);
    idle(BIT_NOM);
    check_eq("pre_rst_data", 32'(rx_if.rx_data), 32'h96);
    rxd = 1'b0;
    repeat (BIT_NOM) @(negedge cpu_clk);
    rxd = 1'b1;
    repeat (2 * BIT_NOM) @(negedge cpu_clk);
    check_eq("pre_rst_busy", 32'(rx_busy), 32'd1);
    #3;
    cpu_rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check_eq("mid_rst_data", 32'(rx_if.rx_data), 32'h00);
    check_eq("mid_rst_busy", 32'(rx_busy), 32'd0);
    check_eq("mid_rst_ferr", 32'(frame_err), 32'd0);
    check_eq("mid_rst_ovr", 32'(overrun), 32'd0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    fe0 = fe_cyc; ov0 = ov_cyc;
    idle(BIT_NOM);
    check_eq("post_rst_busy", 32'(rx_busy), 32'd0);
    check_eq("post_rst_valid", 32'(rx_if.rx_valid), 32'd0);
    send_frame(8'hC3, 1'b1, BIT_NOM);
    idle(BIT_NOM);
    drain("post_rst_c3", 8'hC3);
    check_eq("post_rst_pulses", 32'(fe_cyc - fe0 + ov_cyc - ov0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial receive front end for the CPU's UART port: takes the asynchronous `rxd` line, recovers 8N1 frames using 16x oversampling and mid-bit sampling, and buffers received bytes in a small FIFO. Received bytes go to the CPU's memory-mapped UART register logic through a valid/ready interface. It is the receive-side counterpart of the CPU's UART transmitter that drives `txd`, and sits inside `mycpu` on the `cpu_clk` domain.

## Interface
- `CLK_FREQ`, 50_000_000, `cpu_clk` frequency in Hz.
- `BAUD`, 115200, line rate in bit/s.
- `FIFO_DEPTH`, 4, receive buffer entries; must be a power of two, ≥2.
- `cpu_clk`  in  1  system clock; all logic on its rising edge.
- `cpu_rst`  in  1  reset; asynchronous, active-high.
- `rxd`  in  1  serial line; asynchronous, idle high.
- `rx_data`  out  8  byte at the FIFO head; valid only while `rx_valid`=1.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts `rx_data` this cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- `rx_busy`  out  1  FSM not in IDLE.

## Operation
- Synchroniser: 2 flops on `rxd`, both reset to 1. All decisions use the second stage, `rxd_s`.
- Tick generator: divisor `DIV = (CLK_FREQ + 8*BAUD) / (16*BAUD)`, which is 27 at the defaults. A one-cycle `tick` fires every `DIV` clocks and runs freely in all states. The counter width is `$clog2(DIV)`.
- FSM states, with the transitions checked on `tick` unless noted:
  - IDLE: when `rxd_s`=0 (checked every clock, not gated by `tick`), clear the oversample counter and go to START.
  - START: at the 8th tick, sample `rxd_s`. If 1, treat it as a glitch and go to IDLE. If 0, clear the counter and bit index and go to DATA.
  - DATA: at every 16th tick, shift `rxd_s` into the shift register LSB-first. After bit index 7, go to STOP.
  - STOP: at the 16th tick, sample `rxd_s`.
    - If 1 and the FIFO has room: push the byte and go to IDLE.
    - If 1 and the FIFO is full: pulse `overrun`, drop the byte, and go to IDLE.
    - If 0: pulse `frame_err`, drop the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE on the first clock with `rxd_s`=1. This prevents a break condition from restarting the receiver.
- FIFO:
  - Pop when `rx_valid && rx_ready`.
  - Full is evaluated after the same-cycle pop, so a simultaneous push and pop on a full FIFO accepts the push with no `overrun`.
  - Pointers are `$clog2(FIFO_DEPTH)+1` bits wide and wrap naturally.
  - `rx_ready` while empty is ignored.

## Timing
- Reset values:
  - `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0.
  - FSM=IDLE; FIFO empty; tick counter=0; synchroniser=2'b11.
- Input latency: a `rxd` edge is visible on `rxd_s` after 2 clocks.
- Sampling points: nominal data-bit samples land 16·k+8 ticks after start-edge detection, for k = 1..8. The stop sample is at k = 9.
- Output latency:
  - The push occurs on the clock of the stop sample.
  - `rx_valid` rises on the next clock, with `rx_data` registered from the FIFO head. There is no combinational `rxd`→output path.
  - `frame_err` and `overrun` assert on the clock after the stop sample, for exactly 1 cycle.
- Handshake: `rx_data` holds stable while `rx_valid`=1 and `rx_ready`=0. After a pop, the next entry (if any) appears on the following clock.
- Reset mid-frame: the partial byte is discarded, the FIFO is emptied, and the receiver waits in IDLE for a fresh falling edge.

## Structure
- `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, STOP, WAIT_HIGH).
  - `OVERSAMPLE`=16, `DATA_BITS`=8.
  - A `baud_div(clk, baud)` function, shared with the transmitter.
- Sub-module `uart_rx_fifo`: parameterised synchronous FIFO with push/pop/full/empty, instantiated once.

## Test plan
- Byte 8'hA5 sent at nominal baud with `rx_ready`=1 → `rx_valid`=1 for 1 cycle, `rx_data`=8'hA5, no error pulses.
- Five bytes 8'h01..8'h05 with `rx_ready`=0 (`FIFO_DEPTH`=4) → 4 bytes held; `overrun` pulses once on the 5th stop sample; draining yields 8'h01..8'h04 in order.
- Frame whose stop bit is driven 0, with `rxd` held low for 3 bit times → `frame_err` pulses once, no push, `rx_busy` stays 1 until `rxd` goes high, and no spurious start follows.
- 4-tick low glitch on an idle line → return to IDLE after the START sample; `rx_valid` stays 0 and no pulses occur.
- FIFO full, with `rx_ready`=1 asserted on the exact stop-sample clock of byte 8'h3C → no `overrun`; 8'h3C is last in the drain order.
- Baud error: `BAUD` skewed ±3% on the line side → all of 8'h00, 8'hFF, 8'h55 received correctly. Assert `cpu_rst` mid-DATA → outputs at reset values within the same cycle, and the next clean frame is received correctly.
